// File: rtl/sgb_pkg.sv
// Shared definitions for the Super Game Boy packet link.
//
// Holds the packet length, the {P15, P14} line encodings and the transmitter
// FSM state type. The SNES-side packet receiver imports the same encodings so
// both ends of the link agree on what each line pattern means.
package sgb_pkg;

    // Bytes carried by one SGB command packet.
    localparam int unsigned SGB_PKT_BYTES = 16;

    // Line encodings as {P15, P14}; a released line reads high.
    localparam logic [1:0] P54_IDLE  = 2'b11;
    localparam logic [1:0] P54_RESET = 2'b00;
    localparam logic [1:0] P54_ONE   = 2'b01;
    localparam logic [1:0] P54_ZERO  = 2'b10;

    typedef enum logic [3:0] {
        StIdle,
        StRstLo,
        StRstHi,
        StFetch,
        StBitLo,
        StBitHi,
        StStopLo,
        StStopHi,
        StGap
    } sgb_tx_state_e;

    // A '1' pulls P15 low, a '0' pulls P14 low.
    function automatic logic [1:0] sgb_bit_enc(input logic b);
        return b ? P54_ONE : P54_ZERO;
    endfunction

endpackage

// File: rtl/sgb_packet_tx.sv
// GB-side Super Game Boy packet transmitter.
//
// Pulls 16-byte packets from a byte stream and serializes them onto the
// joypad select lines: a reset pulse (both low), 128 data bits LSB first
// (one line low per bit), a stop '0', and a both-high phase after every low
// phase. Multi-packet transfers insert an idle gap between packets.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   ce         GB clock enable; protocol timing advances only on ce
//   start      one-cycle pulse, starts a transfer when idle
//   pkt_count  packets in the transfer, sampled on start (0 means 1)
//   in_data    next packet byte
//   in_valid   in_data valid
//   in_ready   byte accept strobe (byte moves when in_valid & in_ready)
//   joy_p54    {P15, P14} to the GB joypad, 2'b11 = both released
//   busy       transfer in progress
//   done       one-cycle pulse after the final stop phase
module sgb_packet_tx
    import sgb_pkg::*;
#(
    parameter int unsigned PHASE_CE = 4,
    parameter int unsigned GAP_CE   = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       start,
    input  logic [2:0] pkt_count,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] joy_p54,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] PhaseLoad = CNT_W'(PHASE_CE - 1);
    localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CE - 1);
    localparam logic [3:0]       LastByte  = 4'(SGB_PKT_BYTES - 1);

    sgb_tx_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx_q;
    logic [3:0]       byte_idx_q;
    logic [2:0]       pkts_left_q;

    logic phase_end;
    logic timed_state;

    // FETCH is the only state that accepts bytes; it does not wait on ce.
    assign in_ready = (state_q == StFetch) && in_valid;

    // The current phase ends on the ce tick that finds the counter at zero.
    assign phase_end   = ce && (cnt_q == '0);
    assign timed_state = (state_q != StIdle) && (state_q != StFetch);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            pkts_left_q <= '0;
            joy_p54     <= P54_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            // Free-running countdown; any state transition below reloads it.
            if (timed_state && ce && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    // A start coinciding with done belongs to the old transfer.
                    if (start && !done) begin
                        pkts_left_q <= (pkt_count == 3'd0) ? 3'd1 : pkt_count;
                        busy        <= 1'b1;
                        cnt_q       <= PhaseLoad;
                        joy_p54     <= P54_RESET;
                        state_q     <= StRstLo;
                    end
                end

                StRstLo: begin
                    if (phase_end) begin
                        cnt_q   <= PhaseLoad;
                        joy_p54 <= P54_IDLE;
                        state_q <= StRstHi;
                    end
                end

                StRstHi: begin
                    if (phase_end) begin
                        byte_idx_q <= '0;
                        state_q    <= StFetch;
                    end
                end

                StFetch: begin
                    // Lines stay high while stalled; the receiver only
                    // decodes transitions, so an arbitrarily long wait is safe.
                    if (in_valid) begin
                        shift_q   <= in_data;
                        bit_idx_q <= '0;
                        cnt_q     <= PhaseLoad;
                        joy_p54   <= sgb_bit_enc(in_data[0]);
                        state_q   <= StBitLo;
                    end
                end

                StBitLo: begin
                    if (phase_end) begin
                        cnt_q   <= PhaseLoad;
                        joy_p54 <= P54_IDLE;
                        state_q <= StBitHi;
                    end
                end

                StBitHi: begin
                    if (phase_end) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q != 3'd7) begin
                            // shift_q[1] becomes the LSB after this shift.
                            cnt_q   <= PhaseLoad;
                            joy_p54 <= sgb_bit_enc(shift_q[1]);
                            state_q <= StBitLo;
                        end else if (byte_idx_q != LastByte) begin
                            byte_idx_q <= byte_idx_q + 4'd1;
                            state_q    <= StFetch;
                        end else begin
                            cnt_q   <= PhaseLoad;
                            joy_p54 <= P54_ZERO;
                            state_q <= StStopLo;
                        end
                    end
                end

                StStopLo: begin
                    if (phase_end) begin
                        cnt_q   <= PhaseLoad;
                        joy_p54 <= P54_IDLE;
                        state_q <= StStopHi;
                    end
                end

                StStopHi: begin
                    if (phase_end) begin
                        if (pkts_left_q == 3'd1) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            pkts_left_q <= pkts_left_q - 3'd1;
                            cnt_q       <= GapLoad;
                            state_q     <= StGap;
                        end
                    end
                end

                StGap: begin
                    if (phase_end) begin
                        cnt_q   <= PhaseLoad;
                        joy_p54 <= P54_RESET;
                        state_q <= StRstLo;
                    end
                end

                default: begin
                    joy_p54 <= P54_IDLE;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgb_packet_tx.sv
module tb_sgb_packet_tx;

    localparam int PHASE = 4;
    localparam int GAP   = 16;
    localparam int PKT_CYC = 260 * PHASE + 16;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       start;
    logic [2:0] pkt_count;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] joy_p54;
    logic       busy;
    logic       done;

    sgb_packet_tx #(
        .PHASE_CE (PHASE),
        .GAP_CE   (GAP),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .start     (start),
        .pkt_count (pkt_count),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .joy_p54   (joy_p54),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];

    int ce_div = 1;
    int xfer_acc = 0;
    int acc_total = 0;
    int stall_at = -1;
    int stall_len = 0;

    // Receiver model state.
    int rst_pulses = 0;
    int done_cnt = 0;
    int pkts_rx = 0;
    int ones = 0;
    logic [1:0] first_bit = 2'b11;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock enable: one tick every ce_div cycles.
    initial begin
        int ph;
        ph = 0;
        ce = 1'b1;
        forever begin
            @(negedge clk);
            ph++;
            ce = ((ph % ce_div) == 0);
        end
    end

    // Byte source: accepted bytes move from src_q into the scoreboard.
    initial begin
        logic acc;
        int   stall_cnt;
        acc = 1'b0;
        stall_cnt = 0;
        in_valid = 1'b0;
        in_data = 8'h00;
        forever begin
            @(negedge clk);
            if (acc) begin
                exp_q.push_back(src_q.pop_front());
                xfer_acc++;
                acc_total++;
                if (xfer_acc == stall_at) stall_cnt = stall_len;
            end
            if (stall_cnt > 0) begin
                in_valid = 1'b0;
                stall_cnt--;
            end else begin
                in_valid = (src_q.size() > 0);
                in_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
            end
            #1 acc = in_valid && in_ready && !reset;
        end
    end

    // Receiver model: decodes line transitions and checks phase timing.
    initial begin
        logic [1:0] prev;
        int         run;
        int         bit_cnt;
        int         stop_done;
        logic       in_pkt;
        logic       after_stop;
        logic [7:0] cur;
        logic       b;
        prev = 2'b11;
        run = 0;
        bit_cnt = 0;
        stop_done = -1;
        in_pkt = 1'b0;
        after_stop = 1'b0;
        cur = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                in_pkt = 1'b0;
                after_stop = 1'b0;
                bit_cnt = 0;
                prev = joy_p54;
                run = 1;
            end else begin
                if (done) done_cnt++;
                if (joy_p54 !== prev) begin
                    chk("high_between_lows", 32'((prev == 2'b11) || (joy_p54 == 2'b11)), 1);
                    if (prev != 2'b11) begin
                        chk("low_phase_len", 32'((run <= PHASE * ce_div) &&
                            (run >= (PHASE - 1) * ce_div + 1)), 1);
                    end else if (joy_p54 == 2'b00) begin
                        if (after_stop && (done_cnt == stop_done))
                            chk("gap_len", run, (PHASE + GAP) * ce_div);
                        in_pkt = 1'b1;
                        after_stop = 1'b0;
                        bit_cnt = 0;
                        ones = 0;
                        rst_pulses++;
                    end else begin
                        chk("phase_in_packet", 32'(in_pkt), 1);
                        if (in_pkt && bit_cnt < 128) begin
                            b = (joy_p54 == 2'b01);
                            if (bit_cnt == 0) first_bit = joy_p54;
                            if (b) ones++;
                            cur = {b, cur[7:1]};
                            bit_cnt++;
                            if ((bit_cnt % 8) == 0) begin
                                chk("exp_byte_avail", 32'(exp_q.size() > 0), 1);
                                if (exp_q.size() > 0) chk("rx_byte", cur, exp_q.pop_front());
                            end
                        end else if (in_pkt) begin
                            chk("stop_bit", joy_p54, 2'b10);
                            in_pkt = 1'b0;
                            after_stop = 1'b1;
                            stop_done = done_cnt;
                            pkts_rx++;
                        end
                    end
                    prev = joy_p54;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end
    end

    task automatic run_transfer(input logic [2:0] cnt, input int exp_cyc,
                                input bit start_busy, input bit start_at_done);
        int cyc;
        int seen;
        @(negedge clk);
        pkt_count = cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        seen = 0;
        while (seen == 0 && cyc < 20000) begin
            @(posedge clk);
            #1 cyc++;
            if (start_busy && cyc == 100) start = 1'b1;
            if (start_busy && cyc == 101) start = 1'b0;
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
        if (exp_cyc > 0) chk("done_latency", cyc, exp_cyc);
        chk("busy_at_done", busy, 0);
        if (start_at_done) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_one_cycle", done, 0);
        if (start_at_done) chk("start_at_done_ignored", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int r0;
        int d0;
        int p0;
        int a0;
        int w;
        reset = 1'b1;
        start = 1'b0;
        pkt_count = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_joy", joy_p54, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single packet 0x00..0x0F, with a start pulse ignored mid-transfer.
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        p0 = pkts_rx;
        d0 = done_cnt;
        run_transfer(3'd1, PKT_CYC, 1'b1, 1'b0);
        chk("t1_packets", pkts_rx - p0, 1);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_first_bit", first_bit, 2'b10);

        // 0x01 then zeros; pkt_count 0 means one packet; start at done ignored.
        src_q.push_back(8'h01);
        for (int i = 1; i < 16; i++) src_q.push_back(8'h00);
        p0 = pkts_rx;
        run_transfer(3'd0, PKT_CYC, 1'b0, 1'b1);
        chk("t2_packets", pkts_rx - p0, 1);
        chk("t2_first_bit", first_bit, 2'b01);
        chk("t2_ones", ones, 1);

        // Three packets back to back.
        for (int i = 0; i < 48; i++) src_q.push_back(8'($urandom_range(0, 255)));
        p0 = pkts_rx;
        d0 = done_cnt;
        r0 = rst_pulses;
        a0 = acc_total;
        run_transfer(3'd3, 3 * PKT_CYC + 2 * GAP, 1'b0, 1'b0);
        chk("t3_accepts", acc_total - a0, 48);
        chk("t3_reset_pulses", rst_pulses - r0, 3);
        chk("t3_done_pulses", done_cnt - d0, 1);
        chk("t3_packets", pkts_rx - p0, 3);

        // Source stalls 50 cycles at byte 7.
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'hA5 ^ i));
        xfer_acc = 0;
        stall_at = 7;
        stall_len = 114;
        p0 = pkts_rx;
        run_transfer(3'd1, PKT_CYC + 50, 1'b0, 1'b0);
        chk("t4_packets", pkts_rx - p0, 1);
        stall_at = -1;

        // ce one cycle in five.
        ce_div = 5;
        for (int i = 0; i < 16; i++) src_q.push_back(8'($urandom_range(0, 255)));
        p0 = pkts_rx;
        run_transfer(3'd1, 0, 1'b0, 1'b0);
        chk("t5_packets", pkts_rx - p0, 1);
        @(negedge clk);
        ce_div = 1;

        // Reset during BIT_LO of byte 9, then a clean packet.
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h30 + i));
        xfer_acc = 0;
        d0 = done_cnt;
        @(negedge clk);
        pkt_count = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (xfer_acc < 10 && w < 5000) begin
            @(negedge clk);
            #2 w++;
        end
        chk("t6_reached_byte9", 32'(xfer_acc == 10), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_joy_after_reset", joy_p54, 2'b11);
        chk("t6_busy_after_reset", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        src_q.delete();
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'hC0 + i));
        p0 = pkts_rx;
        run_transfer(3'd1, PKT_CYC, 1'b0, 1'b0);
        chk("t6_packets", pkts_rx - p0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgb_packet_tx.md
Name: sgb_packet_tx

Overview:
- GB-side transmitter for Super Game Boy command packets over the joypad select lines P15/P14.
- Serializes 16-byte packets from a byte stream into the P14/P15 pulse protocol that the SNES-side packet receiver decodes.
- Used as a bench driver for the receiver and for GB-side boot/firmware emulation that sends SGB commands without a running GB CPU.
- Muxed onto joy_p54 in place of the GB core's P1 outputs while busy.

Parameters:
- PHASE_CE, 4, number of ce ticks each line phase is held (min 2).
- GAP_CE, 16, ce ticks of both-high idle between consecutive packets of one transfer.
- CNT_W, 8, width of the phase/gap tick counter; must hold max(PHASE_CE, GAP_CE).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  GB clock enable (gb_clk_en); all protocol timing advances only on ce.
- start  in  1  one-cycle pulse; starts a transfer when idle, ignored when busy.
- pkt_count  in  3  packets in the transfer, sampled on start; 0 is treated as 1.
- in_data  in  8  next packet byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  one-cycle byte accept strobe; the byte transfers when in_valid & in_ready.
- joy_p54  out  2  {P15, P14} driven to the GB joypad; 2'b11 = both released.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final stop phase completes.

Behaviour:
- Reset:
  - joy_p54=2'b11; busy=0, done=0, in_ready=0.
  - FSM returns to IDLE; all counters cleared.
  - A reset asserted mid-packet forces 2'b11 on the next clk edge; no partial completion is signalled.
- Bit encoding: LSB first, byte 0 first.
  - Bit '1' drives P15 low (joy_p54=2'b01).
  - Bit '0' drives P14 low (joy_p54=2'b10).
  - Every low phase is followed by a both-high phase (2'b11).
- FSM states: IDLE, RST_LO, RST_HI, FETCH, BIT_LO, BIT_HI, STOP_LO, STOP_HI, GAP.
  - IDLE: on start, latch pkt_count into pkts_left, set busy, go to RST_LO.
  - RST_LO: joy_p54=2'b00 for PHASE_CE ce ticks, then RST_HI.
  - RST_HI: 2'b11 for PHASE_CE ce ticks, then FETCH with byte_idx=0.
  - FETCH: 2'b11 held. in_ready is asserted only in FETCH when in_valid is high; that cycle loads the shift register and goes to BIT_LO with bit_idx=0.
    - With in_valid low, FETCH stalls indefinitely with lines high; the receiver tolerates this because only transitions are decoded.
    - FETCH is combinational on in_valid, and is the only state that accepts bytes.
  - BIT_LO: drive the encoding of shift[0] for PHASE_CE ticks, then BIT_HI.
  - BIT_HI: 2'b11 for PHASE_CE ticks, then shift right by 1.
    - bit_idx<7: go to BIT_LO.
    - bit_idx==7 and byte_idx<15: go to FETCH with byte_idx+1.
    - bit_idx==7 and byte_idx==15: go to STOP_LO.
  - STOP_LO: stop bit '0', 2'b10 for PHASE_CE ticks; STOP_HI: 2'b11 for PHASE_CE ticks.
    - If pkts_left==1: pulse done, clear busy, go to IDLE.
    - Otherwise: decrement pkts_left, go to GAP.
  - GAP: 2'b11 for GAP_CE ticks, then RST_LO.
- Phase counter:
  - Loads PHASE_CE-1 on state entry and decrements on ce; the state advances on the ce where the counter is 0.
  - With ce idle, every state holds.
- Packet length with ce=1 every cycle and no stalls: 2P reset + 256P bits + 2P stop = 260*P cycles, plus one FETCH cycle per byte (P = PHASE_CE).
- joy_p54 is registered; it must never glitch to 2'b00 except in RST_LO. Low→low transitions between different lines are forbidden; a both-high phase always separates them.
- start while busy is ignored. A start in the same cycle done pulses is ignored.

Decomposition:
- Shared package sgb_pkg holds:
  - SGB_PKT_BYTES=16.
  - Line encodings P54_IDLE=2'b11, P54_RESET=2'b00, P54_ONE=2'b01, P54_ZERO=2'b10.
  - The FSM state enum.
- The receiver's decoder should import the same encodings.
- No sub-module is needed; single FSM with the phase counter inline.

Test Plan:
- Single packet, bytes 0x00..0x0F, PHASE_CE=4, ce=1 → a receiver model captures packet_data[i]=i and new_packet is set; done is asserted 1040+16 cycles after start; the first low phase after reset is P14 (byte0 bit0=0).
- Packet byte0=0x01, rest 0x00 → first data phase joy_p54=2'b01; next 127 data phases are 2'b10; stop phase is 2'b10.
- pkt_count=3 with continuous in_valid → 48 in_ready strobes; three RST_LO pulses separated by GAP_CE ticks of 2'b11; one done pulse.
- in_valid dropped for 50 cycles at byte 7 → lines held 2'b11 throughout the stall; the received packet is still correct; no extra transitions.
- ce asserted 1 in 5 cycles → all phase lengths scale ×5; the receiver clocked with the same ce decodes correctly.
- reset asserted during BIT_LO of byte 9 → joy_p54=2'b11 and busy=0 next cycle; no done pulse; a subsequent start sends a full, correct packet.
